door_hold_timer: RTL and testbench

//  Consumer end of the seconds-count interface driven by the elevator clock source.
//  - Arms a door-hold interval of N seconds and restarts the clock source through its reset input.
//  - Counts second ticks seen on the source's count output, then pulses 'expired'.
//  - Supports extend (obstruction re-arm) and cancel. The door/floor FSM uses 'expired' to close the door.

---
 rtl/elevator_pkg.sv | 21 ++
 rtl/door_hold_timer.sv | 143 ++++++++++++++
 tb/tb_door_hold_timer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator control blocks.
//   SEC_W_DEF : default width of the seconds count from the clock source
//   S_*       : state encodings for the door-hold timer
//   state_e   : typed state enum built on those encodings
package elevator_pkg;

   localparam int unsigned SEC_W_DEF = 4;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   typedef enum logic [1:0] {
      StIdle  = S_IDLE,
      StClear = S_CLEAR,
      StRun   = S_RUN,
      StDone  = S_DONE
   } state_e;

endpackage

// File: rtl/door_hold_timer.sv
// Door-hold timer: consumer end of the seconds-count interface from the elevator clock source.
// Arms an N-second hold interval, restarts the clock source, counts second ticks and pulses
// o_expired when the interval has elapsed. Supports extend (re-arm) and cancel.
// Ports:
//   i_clk       system clock
//   i_reseta    synchronous active-high reset
//   i_start     1-cycle pulse: arm with i_hold_sec
//   i_hold_sec  hold interval in seconds, sampled only with i_start
//   i_extend    1-cycle pulse: restart the current interval with the latched hold value
//   i_cancel    1-cycle pulse: abort without an expired pulse
//   i_sec_in    seconds count from the clock source (wraps)
//   o_sec_clr   to clock source reset input, high for the single CLEAR cycle
//   o_busy      high while in CLEAR or RUN
//   o_expired   1-cycle pulse when the interval elapses
//   o_remaining seconds left in the current interval (0 when idle)
module door_hold_timer
   import elevator_pkg::*;
#(
   parameter int unsigned SEC_W = SEC_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_reseta,
   input  logic             i_start,
   input  logic [SEC_W-1:0] i_hold_sec,
   input  logic             i_extend,
   input  logic             i_cancel,
   input  logic [SEC_W-1:0] i_sec_in,
   output logic             o_sec_clr,
   output logic             o_busy,
   output logic             o_expired,
   output logic [SEC_W-1:0] o_remaining
);

   state_e           r_state;
   logic [SEC_W-1:0] r_hold;
   logic [SEC_W-1:0] r_sec_prev;
   logic [SEC_W-1:0] r_remaining;
   logic             r_sec_clr;
   logic             r_busy;
   logic             r_expired;
   logic             w_tick;

   // Ticks are detected by change, so a wrap from max to 0 still counts as one second.
   assign w_tick = (i_sec_in != r_sec_prev);

   // Outputs are registered together with the state they belong to, so each output
   // assignment below describes the value seen during the next state.
   always_ff @(posedge i_clk) begin
      if (i_reseta) begin
         r_state     <= StIdle;
         r_hold      <= '0;
         r_sec_prev  <= '0;
         r_remaining <= '0;
         r_sec_clr   <= 1'b0;
         r_busy      <= 1'b0;
         r_expired   <= 1'b0;
      end else if (i_cancel) begin
         r_state     <= StIdle;
         r_remaining <= '0;
         r_sec_clr   <= 1'b0;
         r_busy      <= 1'b0;
         r_expired   <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               r_expired <= 1'b0;
               if (i_start) begin
                  r_state   <= StClear;
                  r_hold    <= i_hold_sec;
                  r_sec_clr <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end

            StClear: begin
               if (i_start) begin
                  // Re-arm while still clearing: reload and hold the source in reset.
                  r_hold <= i_hold_sec;
               end else begin
                  r_sec_clr   <= 1'b0;
                  r_remaining <= r_hold;
                  // The source restarts at 0 next cycle, so align the tick reference.
                  r_sec_prev  <= '0;
                  if (r_hold == '0) begin
                     r_state   <= StDone;
                     r_busy    <= 1'b0;
                     r_expired <= 1'b1;
                  end else begin
                     r_state <= StRun;
                  end
               end
            end

            StRun: begin
               r_sec_prev <= i_sec_in;
               if (i_start) begin
                  r_state   <= StClear;
                  r_hold    <= i_hold_sec;
                  r_sec_clr <= 1'b1;
               end else if (i_extend) begin
                  // Any tick in this cycle is dropped; the interval restarts in full.
                  r_state   <= StClear;
                  r_sec_clr <= 1'b1;
               end else if (w_tick && (r_remaining != '0)) begin
                  r_remaining <= r_remaining - SEC_W'(1);
                  if (r_remaining == SEC_W'(1)) begin
                     r_state   <= StDone;
                     r_busy    <= 1'b0;
                     r_expired <= 1'b1;
                  end
               end
            end

            StDone: begin
               r_expired   <= 1'b0;
               r_remaining <= '0;
               if (i_start) begin
                  r_state   <= StClear;
                  r_hold    <= i_hold_sec;
                  r_sec_clr <= 1'b1;
                  r_busy    <= 1'b1;
               end else begin
                  r_state <= StIdle;
               end
            end

            default: begin
               r_state     <= StIdle;
               r_remaining <= '0;
               r_sec_clr   <= 1'b0;
               r_busy      <= 1'b0;
               r_expired   <= 1'b0;
            end
         endcase
      end
   end

   assign o_sec_clr   = r_sec_clr;
   assign o_busy      = r_busy;
   assign o_expired   = r_expired;
   assign o_remaining = r_remaining;

endmodule

// File: tb/tb_door_hold_timer.sv
// Directed bench for door_hold_timer, paired with a behavioural seconds source
// (2 clk per second, restarted by sec_clr) or with sec_in driven directly.
module tb_door_hold_timer;

   logic       clk;
   logic       reseta;
   logic       start;
   logic [3:0] hold_sec;
   logic       extend;
   logic       cancel;
   logic [3:0] sec_in;
   logic       sec_clr;
   logic       busy;
   logic       expired;
   logic [3:0] remaining;

   logic       direct_en;
   logic [3:0] direct_val;
   logic [3:0] src_cnt;
   logic       src_div;

   int n_checks;
   int n_fail;

   door_hold_timer #(
      .SEC_W(4)
   ) dut (
      .i_clk      (clk),
      .i_reseta   (reseta),
      .i_start    (start),
      .i_hold_sec (hold_sec),
      .i_extend   (extend),
      .i_cancel   (cancel),
      .i_sec_in   (sec_in),
      .o_sec_clr  (sec_clr),
      .o_busy     (busy),
      .o_expired  (expired),
      .o_remaining(remaining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Clock source: one count step every 2 clk, synchronous reset from sec_clr.
   always_ff @(posedge clk) begin
      if (reseta || sec_clr) begin
         src_cnt <= 4'd0;
         src_div <= 1'b0;
      end else if (src_div) begin
         src_div <= 1'b0;
         src_cnt <= src_cnt + 4'd1;
      end else begin
         src_div <= 1'b1;
      end
   end

   assign sec_in = direct_en ? direct_val : src_cnt;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reseta = 1'b1;
      step(3);
      n_checks++; if (sec_clr !== 1'b0) begin n_fail++; $display("FAIL rst_sec_clr got=%b exp=0", sec_clr); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
      n_checks++; if (expired !== 1'b0) begin n_fail++; $display("FAIL rst_expired got=%b exp=0", expired); end
      n_checks++; if (remaining !== 4'd0) begin n_fail++; $display("FAIL rst_remaining got=%0d exp=0", remaining); end
      reseta = 1'b0;
      step(2);
   endtask

   task automatic test_hold3;
      hold_sec = 4'd3; start = 1'b1;
      step(1); start = 1'b0;
      n_checks++; if (sec_clr !== 1'b1) begin n_fail++; $display("FAIL t1_sec_clr_hi got=%b exp=1", sec_clr); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_clear got=%b exp=1", busy); end
      step(1);
      n_checks++; if (sec_clr !== 1'b0) begin n_fail++; $display("FAIL t1_sec_clr_lo got=%b exp=0", sec_clr); end
      n_checks++; if (remaining !== 4'd3) begin n_fail++; $display("FAIL t1_rem3 got=%0d exp=3", remaining); end
      step(3);
      n_checks++; if (remaining !== 4'd2) begin n_fail++; $display("FAIL t1_rem2 got=%0d exp=2", remaining); end
      step(2);
      n_checks++; if (remaining !== 4'd1) begin n_fail++; $display("FAIL t1_rem1 got=%0d exp=1", remaining); end
      step(1);
      n_checks++; if (expired !== 1'b0) begin n_fail++; $display("FAIL t1_early_exp got=%b exp=0", expired); end
      step(1);
      n_checks++; if (expired !== 1'b1) begin n_fail++; $display("FAIL t1_expired got=%b exp=1", expired); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_done got=%b exp=0", busy); end
      n_checks++; if (remaining !== 4'd0) begin n_fail++; $display("FAIL t1_rem0 got=%0d exp=0", remaining); end
      step(1);
      n_checks++; if (expired !== 1'b0) begin n_fail++; $display("FAIL t1_pulse_len got=%b exp=0", expired); end
      step(2);
   endtask

   task automatic test_hold0;
      hold_sec = 4'd0; start = 1'b1;
      step(1); start = 1'b0;
      n_checks++; if (sec_clr !== 1'b1) begin n_fail++; $display("FAIL t2_sec_clr got=%b exp=1", sec_clr); end
      n_checks++; if (expired !== 1'b0) begin n_fail++; $display("FAIL t2_exp_clear got=%b exp=0", expired); end
      step(1);
      n_checks++; if (expired !== 1'b1) begin n_fail++; $display("FAIL t2_expired got=%b exp=1", expired); end
      n_checks++; if (remaining !== 4'd0) begin n_fail++; $display("FAIL t2_rem got=%0d exp=0", remaining); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t2_busy got=%b exp=0", busy); end
      step(1);
      n_checks++; if (expired !== 1'b0) begin n_fail++; $display("FAIL t2_pulse_len got=%b exp=0", expired); end
      step(2);
   endtask

   task automatic test_extend;
      hold_sec = 4'd4; start = 1'b1;
      step(1); start = 1'b0;
      step(6);
      n_checks++; if (remaining !== 4'd2) begin n_fail++; $display("FAIL t3_rem_pre got=%0d exp=2", remaining); end
      extend = 1'b1;
      step(1); extend = 1'b0;
      n_checks++; if (sec_clr !== 1'b1) begin n_fail++; $display("FAIL t3_sec_clr got=%b exp=1", sec_clr); end
      step(1);
      n_checks++; if (remaining !== 4'd4) begin n_fail++; $display("FAIL t3_rem4 got=%0d exp=4", remaining); end
      step(8);
      n_checks++; if (remaining !== 4'd1) begin n_fail++; $display("FAIL t3_rem1 got=%0d exp=1", remaining); end
      n_checks++; if (expired !== 1'b0) begin n_fail++; $display("FAIL t3_early_exp got=%b exp=0", expired); end
      step(1);
      n_checks++; if (expired !== 1'b1) begin n_fail++; $display("FAIL t3_expired got=%b exp=1", expired); end
      step(3);
   endtask

   task automatic test_cancel;
      int pulses;
      hold_sec = 4'd5; start = 1'b1;
      step(1); start = 1'b0;
      step(6);
      n_checks++; if (remaining !== 4'd3) begin n_fail++; $display("FAIL t4_rem_pre got=%0d exp=3", remaining); end
      cancel = 1'b1;
      step(1); cancel = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t4_busy got=%b exp=0", busy); end
      n_checks++; if (remaining !== 4'd0) begin n_fail++; $display("FAIL t4_rem got=%0d exp=0", remaining); end
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         if (expired === 1'b1) pulses++;
         step(1);
      end
      n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL t4_no_expired got=%0d pulses exp=0", pulses); end
   endtask

   task automatic test_wrap;
      logic [3:0] vals [15];
      int pulses;
      for (int i = 0; i < 6; i++) vals[i] = 4'(10 + i);
      for (int i = 6; i < 15; i++) vals[i] = 4'(i - 6);
      direct_en = 1'b1; direct_val = 4'd0;
      hold_sec = 4'd15; start = 1'b1;
      step(1); start = 1'b0;
      step(1);
      n_checks++; if (remaining !== 4'd15) begin n_fail++; $display("FAIL t5_rem15 got=%0d exp=15", remaining); end
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         direct_val = vals[i];
         step(1);
         if (expired === 1'b1) pulses++;
         if (i == 14) begin
            n_checks++; if (expired !== 1'b1) begin n_fail++; $display("FAIL t5_expired got=%b exp=1", expired); end
         end else if (i == 5 || i == 6 || i == 13) begin
            n_checks++;
            if (remaining !== 4'(14 - i)) begin
               n_fail++; $display("FAIL t5_rem_step%0d got=%0d exp=%0d", i, remaining, 14 - i);
            end
         end
         step(1);
         if (expired === 1'b1) pulses++;
      end
      step(3);
      n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL t5_pulse_count got=%0d exp=1", pulses); end
      direct_en = 1'b0;
      step(2);
   endtask

   task automatic test_back_to_back;
      int pulses;
      // Reset mid-interval.
      hold_sec = 4'd3; start = 1'b1;
      step(1); start = 1'b0;
      step(5);
      reseta = 1'b1;
      step(1); reseta = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t6_rst_busy got=%b exp=0", busy); end
      n_checks++; if (remaining !== 4'd0) begin n_fail++; $display("FAIL t6_rst_rem got=%0d exp=0", remaining); end
      n_checks++; if (sec_clr !== 1'b0) begin n_fail++; $display("FAIL t6_rst_sec_clr got=%b exp=0", sec_clr); end
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         if (expired === 1'b1) pulses++;
         step(1);
      end
      n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL t6_rst_no_exp got=%0d exp=0", pulses); end
      // Start and extend together in RUN: start wins and reloads the hold value.
      hold_sec = 4'd2; start = 1'b1;
      step(1); start = 1'b0;
      step(2);
      hold_sec = 4'd6; start = 1'b1; extend = 1'b1;
      step(1); start = 1'b0; extend = 1'b0;
      n_checks++; if (sec_clr !== 1'b1) begin n_fail++; $display("FAIL t6_se_sec_clr got=%b exp=1", sec_clr); end
      step(1);
      n_checks++; if (remaining !== 4'd6) begin n_fail++; $display("FAIL t6_se_rem got=%0d exp=6", remaining); end
      cancel = 1'b1;
      step(1); cancel = 1'b0;
      step(2);
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      reseta = 1'b1; start = 1'b0; hold_sec = 4'd0; extend = 1'b0; cancel = 1'b0;
      direct_en = 1'b0; direct_val = 4'd0;
      test_reset();
      test_hold3();
      test_hold0();
      test_extend();
      test_cancel();
      test_wrap();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
